// File: rtl/rfile_pkg.sv
// Shared definitions for the scoreboarded register file.
//   XLEN_DEF      : default data width
//   sweep_state_t : clear-engine state encoding
//   addr_w()      : address width for a given register count
package rfile_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic {
    SWEEP = 1'b0,
    IDLE  = 1'b1
  } sweep_state_t;

  // Smallest w with 2**w >= n (n >= 2 in practice).
  function automatic int addr_w(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/rfile_sb_sweep.sv
// Clear engine for rfile_sb: walks every register index once, writing zero,
// after reset or on a clear request, then parks in IDLE.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   clr_req      : restart the sweep (only looked at in IDLE)
//   ready        : high in IDLE
//   sweep_we     : array write strobe for the zeroing pass
//   sweep_addr   : index being zeroed this cycle
//   busy_clr     : clear the whole scoreboard at the next edge
//
// state | meaning
// ------+----------------------------------------------
// SWEEP | zeroing reg[cnt], one register per edge
// IDLE  | array usable, waiting for clr_req
module rfile_sb_sweep
  import rfile_pkg::*;
#(
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_req,
  output logic          ready,
  output logic          sweep_we,
  output logic [AW-1:0] sweep_addr,
  output logic          busy_clr
);

  sweep_state_t  state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SWEEP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NREG is a power of two, so the counter wraps to 0 by itself as it
  // leaves the last index.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      SWEEP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == AW'(NREG - 1)) state_d = IDLE;
      end
      IDLE: begin
        if (clr_req) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      default: state_d = SWEEP;
    endcase
  end

  always_comb begin
    ready      = (state_q == IDLE);
    sweep_we   = (state_q == SWEEP);
    sweep_addr = cnt_q;
    busy_clr   = sweep_we | (ready & clr_req);
  end

endmodule

// File: rtl/rfile_sb.sv
// Parametrised register file with per-register busy scoreboard,
// hardwired-zero x0 and a sequential clear engine.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   clr_req / ready   : request a full clear / array usable
//   rd_en, rd_addr    : NRP read ports, port p address at [p*AW +: AW]
//   rd_data, rd_busy  : combinational read data and busy bit per port
//   wr_en/addr/data   : writeback port, clears busy of the destination
//   rsv_en/addr       : reserve a destination; rsv_ok when accepted
// Optional build macro RFILE_SB_BYPASS_EN: forward same-cycle writeback
// data onto matching read ports.
module rfile_sb
  import rfile_pkg::*;
#(
  parameter  int XLEN = XLEN_DEF,
  parameter  int NREG = 32,
  parameter  int NRP  = 2,
  localparam int AW   = addr_w(NREG)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr_req,
  output logic                ready,
  input  logic [NRP-1:0]      rd_en,
  input  logic [NRP*AW-1:0]   rd_addr,
  output logic [NRP*XLEN-1:0] rd_data,
  output logic [NRP-1:0]      rd_busy,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  output logic                rsv_ok
);

  logic [XLEN-1:0] mem [NREG];
  logic [NREG-1:0] busy;
  logic            sweep_we;
  logic [AW-1:0]   sweep_addr;
  logic            busy_clr;
  logic            wr_fire;

  rfile_sb_sweep #(
    .NREG (NREG),
    .AW   (AW)
  ) u_sweep (
    .clk        (clk),
    .reset      (reset),
    .clr_req    (clr_req),
    .ready      (ready),
    .sweep_we   (sweep_we),
    .sweep_addr (sweep_addr),
    .busy_clr   (busy_clr)
  );

  assign wr_fire = ready & wr_en & (wr_addr != '0);
  assign rsv_ok  = ready & rsv_en & ((rsv_addr == '0) | ~busy[rsv_addr]);

  // Array contents are not reset; the sweep zeroes them instead.
  always_ff @(posedge clk) begin
    if (sweep_we)     mem[sweep_addr] <= '0;
    else if (wr_fire) mem[wr_addr]    <= wr_data;
  end

  // Reservation is applied after the write so it wins on a shared address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else if (busy_clr) begin
      busy <= '0;
    end else begin
      if (wr_fire) busy[wr_addr] <= 1'b0;
      if (rsv_ok && rsv_addr != '0) busy[rsv_addr] <= 1'b1;
    end
  end

  for (genvar p = 0; p < NRP; p++) begin : g_rd
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
    logic            b;

    assign a = rd_addr[p*AW +: AW];

    always_comb begin
      d = '0;
      b = 1'b0;
      if (ready && rd_en[p] && a != '0) begin
        d = mem[a];
        b = busy[a];
`ifdef RFILE_SB_BYPASS_EN
        if (wr_en && wr_addr == a) begin
          d = wr_data;
          b = 1'b0;
        end
`endif
      end
    end

    assign rd_data[p*XLEN +: XLEN] = d;
    assign rd_busy[p]              = b;
  end

endmodule

// File: tb/tb_rfile_sb.sv
// Directed self-checking bench for rfile_sb (XLEN=32, NREG=32, NRP=2).
// Honours RFILE_SB_BYPASS_EN for the forwarding expectations.
module tb_rfile_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic        clr_req;
  logic        ready;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic        rsv_ok;

  int n_checks = 0;
  int n_errors = 0;

  rfile_sb #(.XLEN(32), .NREG(32), .NRP(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .clr_req  (clr_req),
    .ready    (ready),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .rsv_ok   (rsv_ok)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_en   = 2'b11;
    rd_addr = {a1, a0};
    #1;
  endtask

  task automatic idle_inputs();
    clr_req = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_addr = '0; rd_en = '0; rd_addr = '0;
  endtask

  // Counts edges until ready rises, bounded.
  task automatic wait_ready(input string tag, input int exp_edges);
    int n;
    n = 0;
    while (!ready && n < 40) begin
      step();
      n++;
    end
    check(tag, 32'(n), 32'(exp_edges));
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    #1;
    check("reset_ready", {31'b0, ready}, 32'd0);
    rsv_en = 1'b1; rsv_addr = 5'd7; rd_en = 2'b11; rd_addr = {5'd7, 5'd7};
    #1;
    check("reset_rsv_ok", {31'b0, rsv_ok}, 32'd0);
    check("reset_rd_data", rd_data[31:0], 32'd0);
    check("reset_rd_busy", {30'b0, rd_busy}, 32'd0);
    idle_inputs();
    repeat (3) step();
    reset = 1'b0;
    wait_ready("initial_sweep_edges", 32);

    // Fill with garbage and leave some registers busy.
    for (int i = 1; i < 32; i++) begin
      wr_en = 1'b1; wr_addr = 5'(i); wr_data = (32'h01010101 * i) ^ 32'hA5A5A5A5;
      step();
    end
    wr_en = 1'b0;
    rsv_en = 1'b1; rsv_addr = 5'd12; step();
    rsv_addr = 5'd20; step();
    rsv_en = 1'b0;
    rd(5'd12, 5'd9);
    check("garbage_busy12", {31'b0, rd_busy[0]}, 32'd1);
    check("garbage_reg9", rd_data[63:32], (32'h01010101 * 9) ^ 32'hA5A5A5A5);

    // Reset, restart mid-sweep, and push traffic that must be ignored.
    idle_inputs();
    reset = 1'b1; #1;
    check("async_reset_ready", {31'b0, ready}, 32'd0);
    step(); reset = 1'b0;
    repeat (10) step();
    reset = 1'b1; step(); reset = 1'b0;
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hFFFF_FFFF;
    rsv_en = 1'b1; rsv_addr = 5'd6; clr_req = 1'b1;
    #1;
    check("sweep_rsv_ok", {31'b0, rsv_ok}, 32'd0);
    wait_ready("restart_sweep_edges", 32);
    idle_inputs();
    for (int i = 0; i < 32; i++) begin
      rd(5'(i), 5'(31 - i));
      check($sformatf("cleared_p0_r%0d", i), rd_data[31:0], 32'd0);
      check($sformatf("cleared_busy_r%0d", i), {30'b0, rd_busy}, 32'd0);
    end

    // Basic write, dual-port read of the same register, x0 write.
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; step();
    wr_addr = 5'd0; wr_data = 32'h1; step();
    wr_en = 1'b0;
    rd(5'd5, 5'd5);
    check("wr5_p0", rd_data[31:0], 32'hDEADBEEF);
    check("wr5_p1", rd_data[63:32], 32'hDEADBEEF);
    rd(5'd0, 5'd0);
    check("x0_data", rd_data[31:0], 32'd0);
    check("x0_busy", {30'b0, rd_busy}, 32'd0);

    // Reserve, reject, release by writeback.
    rsv_en = 1'b1; rsv_addr = 5'd7; #1;
    check("rsv7_ok", {31'b0, rsv_ok}, 32'd1);
    step();
    rd(5'd7, 5'd5);
    check("rsv7_again_ok", {31'b0, rsv_ok}, 32'd0);
    check("rsv7_busy", {31'b0, rd_busy[0]}, 32'd1);
    check("rsv7_p1_not_busy", {31'b0, rd_busy[1]}, 32'd0);
    rsv_en = 1'b0;
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'd9; #1;
`ifdef RFILE_SB_BYPASS_EN
    check("wr7_busy_samecyc", {31'b0, rd_busy[0]}, 32'd0);
    check("wr7_data_samecyc", rd_data[31:0], 32'd9);
`else
    check("wr7_busy_samecyc", {31'b0, rd_busy[0]}, 32'd1);
    check("wr7_data_samecyc", rd_data[31:0], 32'd0);
`endif
    step(); wr_en = 1'b0; #1;
    check("wr7_busy_after", {31'b0, rd_busy[0]}, 32'd0);
    check("wr7_data_after", rd_data[31:0], 32'd9);

    // Write to a busy register with a same-cycle reserve: rejected, busy ends 0.
    rsv_en = 1'b1; rsv_addr = 5'd8; step();
    wr_en = 1'b1; wr_addr = 5'd8; wr_data = 32'd3; #1;
    check("busy8_rsv_ok", {31'b0, rsv_ok}, 32'd0);
    step(); idle_inputs();
    rd(5'd8, 5'd8);
    check("busy8_after_busy", {31'b0, rd_busy[0]}, 32'd0);
    check("busy8_after_data", rd_data[31:0], 32'd3);

    // Same-cycle write and accepted reserve to a free register: reservation wins.
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
    rsv_en = 1'b1; rsv_addr = 5'd3; #1;
    check("wr_rsv3_ok", {31'b0, rsv_ok}, 32'd1);
    step(); idle_inputs();
    rd(5'd3, 5'd0);
    check("wr_rsv3_data", rd_data[31:0], 32'h33);
    check("wr_rsv3_busy", {31'b0, rd_busy[0]}, 32'd1);

    // x0 reservations always accepted, never set busy.
    rsv_en = 1'b1; rsv_addr = 5'd0; #1;
    check("rsv0_ok", {31'b0, rsv_ok}, 32'd1);
    step(); #1;
    check("rsv0_ok_again", {31'b0, rsv_ok}, 32'd1);
    check("rsv0_busy", {31'b0, rd_busy[1]}, 32'd0);
    rsv_en = 1'b0;

    // Forwarding behaviour on port 0; port 1 on another register unaffected.
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'd11; step();
    wr_data = 32'd77;
    rd(5'd4, 5'd5);
`ifdef RFILE_SB_BYPASS_EN
    check("byp4_samecyc", rd_data[31:0], 32'd77);
`else
    check("byp4_samecyc", rd_data[31:0], 32'd11);
`endif
    check("byp_p1_other", rd_data[63:32], 32'hDEADBEEF);
    step(); wr_en = 1'b0; #1;
    check("byp4_next", rd_data[31:0], 32'd77);

    // Clear request: ready falls at the edge, ignores writes for 32 edges.
    wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'd42; step();
    wr_en = 1'b0;
    clr_req = 1'b1; #1;
    check("clr_ready_before_edge", {31'b0, ready}, 32'd1);
    step(); clr_req = 1'b0;
    check("clr_ready_fell", {31'b0, ready}, 32'd0);
    wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'd99;
    rsv_en = 1'b1; rsv_addr = 5'd11;
    wait_ready("clr_sweep_edges", 32);
    idle_inputs();
    rd(5'd10, 5'd3);
    check("clr_reg10", rd_data[31:0], 32'd0);
    check("clr_busy3", {31'b0, rd_busy[1]}, 32'd0);
    rd(5'd11, 5'd8);
    check("clr_busy11", {31'b0, rd_busy[0]}, 32'd0);
    check("clr_reg8", rd_data[63:32], 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/rfile_sb.md
Name: rfile_sb

Overview:
Parametrised successor to the core register file.
- Configurable width, depth and number of read ports.
- Per-register scoreboard (busy bits) with a reserve/accept handshake for pipelined issue.
- Hardwired-zero x0.
- Sequential clear engine that zeroes the array after reset or on request.
- Sits between decode/issue (reads, reservations) and writeback (writes).

Parameters:
XLEN, 32, data width in bits
NREG, 32, number of registers (power of 2, >=4); AW = clog2(NREG) is a derived localparam
NRP, 2, number of independent read ports

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
clr_req  in  1  request a full array clear (honoured only in IDLE)
ready  out  1  high when in IDLE (array usable)
rd_en  in  NRP  per-port read enable
rd_addr  in  NRP*AW  port p address at [p*AW +: AW]
rd_data  out  NRP*XLEN  port p data at [p*XLEN +: XLEN]
rd_busy  out  NRP  scoreboard bit of the addressed register, per port
wr_en  in  1  writeback enable
wr_addr  in  AW  writeback destination
wr_data  in  XLEN  writeback data
rsv_en  in  1  reserve destination (mark pending)
rsv_addr  in  AW  register to reserve
rsv_ok  out  1  reservation accepted this cycle

Behaviour:
- FSM states:
  - SWEEP: clearing the array. Reset forces SWEEP, sweep counter cnt=0, busy vector all 0.
  - IDLE: normal operation.
- Reset values: ready=0, rsv_ok=0, rd_data=0, rd_busy=0.
- SWEEP:
  - Each posedge writes 0 to reg[cnt] and increments cnt.
  - On the edge that clears reg[NREG-1]: enter IDLE; ready=1 from that edge.
  - ready therefore rises exactly NREG edges after reset release.
  - During SWEEP: wr_en, rsv_en and clr_req are ignored; rd_data=0; rd_busy=0; rsv_ok=0.
- IDLE, clr_req=1: next edge enters SWEEP with cnt=0 and clears all busy bits; ready falls at that edge.
- Reset asserted mid-SWEEP: restarts at cnt=0.
- Reads: combinational.
  - rd_data[p] = reg[rd_addr[p]] if rd_en[p], else 0.
  - rd_busy[p] = busy[rd_addr[p]] & rd_en[p].
- Write: if wr_en and wr_addr!=0, reg[wr_addr] <= wr_data and busy[wr_addr] <= 0 at posedge.
- Reserve:
  - rsv_ok = ready & rsv_en & (rsv_addr==0 | !busy[rsv_addr]).
  - If rsv_ok and rsv_addr!=0, busy[rsv_addr] <= 1.
  - A rejected reservation changes nothing; the requester holds rsv_en until accepted.
- Same-cycle write and accepted reservation to the same address: data is written; busy ends 1 (reservation wins).
- Write to an address that was busy, with a same-cycle reserve to that address: rsv_ok=0 (busy evaluated pre-edge); busy ends 0.
- x0: reads 0, never busy, writes dropped, reservations always accepted when ready and never set busy.
- Multiple read ports may address the same register; all return the same value.

Optional Feature:
RFILE_SB_BYPASS_EN
- Defined: write-through forwarding. If wr_en & wr_addr==rd_addr[p] & wr_addr!=0 & rd_en[p] & ready, rd_data[p]=wr_data and rd_busy[p]=0 in the same cycle.
- Undefined: reads return the pre-edge array value and busy bit; the written value is visible from the next cycle.

Decomposition:
- Package rfile_pkg:
  - XLEN default constant.
  - sweep state enum {SWEEP, IDLE}.
  - AW helper function.
- One natural sub-module, rfile_sb_sweep: the SWEEP/IDLE FSM and counter. Outputs ready, sweep_we, sweep_addr, busy_clr.
- Array, scoreboard and bypass stay in the top module.

Test Plan:
- Reset pulse, preload garbage via hierarchical force -> ready=0 for exactly 32 edges, then 1; every register reads 0.
- wr_en, wr_addr=5, wr_data=32'hDEADBEEF; next cycle read port0 addr5, port1 addr5 -> both 32'hDEADBEEF. Write to x0 with 32'h1 -> reads 0.
- rsv_en addr7 -> rsv_ok=1, rd_busy for addr7=1 next cycle. Second rsv addr7 -> rsv_ok=0. wr addr7 data 9 -> busy 0 next cycle, data 9.
- Same-cycle wr addr3 and rsv addr3 (not busy) -> rsv_ok=1; after edge reg3=wr_data, busy3=1.
- clr_req after writing reg10=42 -> ready low 32 cycles; wr_en ignored meanwhile; reg10 reads 0 after; all busy 0.
- With RFILE_SB_BYPASS_EN: wr addr4=77 while reading addr4 -> rd_data=77 same cycle. Without the macro -> old value that cycle, 77 next cycle.
